// File: rtl/image_mm_burst_reader.sv
// Avalon-MM burst read master: streams a contiguous block of words from a
// latency-1 on-chip RAM slave onto a valid/ready stream through a small FIFO.
module image_mm_burst_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic              m_chipselect_r;
  logic [ADDR_W-1:0] m_address_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issue_left_r;
  logic [LEN_W-1:0]  acc_cnt_r;
  logic              rd_pending_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];

  logic              push_s;
  logic              pop_s;
  logic              last_pop_s;
  logic              credit_ok_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [CNT_W:0]    credit_used_s;

  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;
  assign busy         = busy_r;
  assign done         = done_r;
  assign m_chipselect = m_chipselect_r;
  assign m_address    = m_address_r;
  assign st_valid     = (count_r != {CNT_W{1'b0}});
  assign st_data      = st_valid ? fifo_mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign st_last      = st_valid && busy_r && (acc_cnt_r == len_r - LEN_W'(1));

  // Data returned by the RAM lands in the FIFO the cycle after its request.
  assign push_s     = rd_pending_r;
  assign pop_s      = st_valid && st_ready;
  assign last_pop_s = pop_s && (acc_cnt_r == len_r - LEN_W'(1));

  // Occupancy after this edge plus the read whose data arrives next cycle
  // decides whether another request may be launched.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
    credit_used_s = {1'b0, count_next_s} + (CNT_W + 1)'(m_chipselect_r);
    if (credit_used_s < (CNT_W + 1)'(FIFO_DEPTH)) begin
      credit_ok_s = 1'b1;
    end else begin
      credit_ok_s = 1'b0;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= m_readdata;
    end
  end

  // FIFO pointers, occupancy and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      rd_pending_r <= 1'b0;
    end else begin
      rd_pending_r <= m_chipselect_r;
      count_r      <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Transfer control FSM; the start cycle itself launches the first read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      m_chipselect_r <= 1'b0;
      m_address_r    <= {ADDR_W{1'b0}};
      addr_r         <= {ADDR_W{1'b0}};
      len_r          <= {LEN_W{1'b0}};
      issue_left_r   <= {LEN_W{1'b0}};
      acc_cnt_r      <= {LEN_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (pop_s) begin
        acc_cnt_r <= acc_cnt_r + LEN_W'(1);
      end
      case (state_r)
        IDLE: begin
          m_chipselect_r <= 1'b0;
          if (start) begin
            if (length == {LEN_W{1'b0}}) begin
              done_r <= 1'b1;
            end else begin
              len_r          <= length;
              acc_cnt_r      <= {LEN_W{1'b0}};
              busy_r         <= 1'b1;
              m_chipselect_r <= 1'b1;
              m_address_r    <= base_addr;
              addr_r         <= base_addr + ADDR_W'(1);
              issue_left_r   <= length - LEN_W'(1);
              state_r        <= (length == LEN_W'(1)) ? DRAIN : READ;
            end
          end
        end
        READ: begin
          if (credit_ok_s) begin
            m_chipselect_r <= 1'b1;
            m_address_r    <= addr_r;
            addr_r         <= addr_r + ADDR_W'(1);
            issue_left_r   <= issue_left_r - LEN_W'(1);
            if (issue_left_r == LEN_W'(1)) begin
              state_r <= DRAIN;
            end
          end else begin
            m_chipselect_r <= 1'b0;
          end
        end
        DRAIN: begin
          m_chipselect_r <= 1'b0;
          if (last_pop_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= FINISH;
          end
        end
        FINISH: begin
          m_chipselect_r <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          m_chipselect_r <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_mm_burst_reader.sv
// Directed bench for image_mm_burst_reader with a latency-1 RAM model
// returning mem[i] = i and a negedge stream/bus monitor.
module tb_image_mm_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] base_addr;
  logic [13:0] length;
  logic        busy;
  logic        done;
  logic [13:0] m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic        m_clken;
  logic [31:0] m_readdata = 32'h0;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_last;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] data_q [$];
  bit          last_q [$];
  logic [13:0] addr_q [$];
  int issued, accepted, done_cnt, done_cyc, last_acc_cyc, credit_viol, start_cyc;
  bit busy_seen;
  bit mon_clr = 1'b0;

  image_mm_burst_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_byteenable(m_byteenable), .m_clken(m_clken),
    .m_readdata(m_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_last(st_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave model: word i holds value i, data valid the cycle after request.
  always @(posedge clk) begin
    if (m_chipselect) m_readdata <= {18'h0, m_address};
  end

  // Monitor: records requests, accepted words and done pulses.
  always @(negedge clk) begin
    if (mon_clr) begin
      data_q.delete(); last_q.delete(); addr_q.delete();
      issued = 0; accepted = 0; done_cnt = 0; credit_viol = 0; busy_seen = 1'b0;
    end else begin
      if (m_chipselect) begin
        if (issued - accepted >= 4) credit_viol++;
        addr_q.push_back(m_address);
        issued++;
      end
      if (st_valid && st_ready) begin
        data_q.push_back(st_data);
        last_q.push_back(st_last);
        accepted++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [13:0] b, input logic [13:0] l);
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != 0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; st_ready = 1'b1; base_addr = 14'h0; length = 14'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, m_chipselect, st_valid, st_last} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 00000", {busy, done, m_chipselect, st_valid, st_last});
    end
    checks++;
    if (m_address !== 14'h0 || st_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: addr=%h data=%h required 0/0", m_address, st_data);
    end
    checks++;
    if (m_write !== 1'b0 || m_byteenable !== 4'hF || m_clken !== 1'b1) begin
      failures++;
      $display("FAIL tied_outputs: write=%b be=%h clken=%b required 0/F/1", m_write, m_byteenable, m_clken);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_mon();
    st_ready = 1'b1;
    pulse_start(14'h0010, 14'd8);
    wait_done(60, "basic");
    checks++;
    if (data_q.size() != 8 || addr_q.size() != 8) begin
      failures++;
      $display("FAIL basic_count: words=%0d reqs=%0d required 8/8", data_q.size(), addr_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ed;
      logic [13:0] ea;
      ed = 32'h10 + 32'(i);
      ea = 14'h10 + 14'(i);
      checks++;
      if (data_q[i] !== ed || addr_q[i] !== ea || last_q[i] !== (i == 7)) begin
        failures++;
        $display("FAIL basic_word%0d: data=%h addr=%h last=%b required %h/%h/%b",
                 i, data_q[i], addr_q[i], last_q[i], ed, ea, (i == 7));
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_acc_cyc + 1) begin
      failures++;
      $display("FAIL basic_done: pulses=%0d at cycle %0d required 1 at %0d", done_cnt, done_cyc, last_acc_cyc + 1);
    end
    checks++;
    if (last_acc_cyc - start_cyc > 11) begin
      failures++;
      $display("FAIL basic_throughput: last accept %0d cycles after start required <=11", last_acc_cyc - start_cyc);
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    pulse_start(14'h0020, 14'd0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
      failures++;
      $display("FAIL zero_done: pulses=%0d at %0d required 1 at %0d", done_cnt, done_cyc, start_cyc + 1);
    end
    checks++;
    if (busy_seen || issued != 0) begin
      failures++;
      $display("FAIL zero_quiet: busy_seen=%b reqs=%0d required 0/0", busy_seen, issued);
    end
  endtask

  task automatic test_wrap();
    logic [13:0] ea;
    clear_mon();
    st_ready = 1'b1;
    pulse_start(14'h3FFE, 14'd4);
    wait_done(40, "wrap");
    ea = 14'h3FFE;
    checks++;
    if (data_q.size() != 4) begin
      failures++;
      $display("FAIL wrap_count: words=%0d required 4", data_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_q[i] !== ea || data_q[i] !== {18'h0, ea}) begin
        failures++;
        $display("FAIL wrap_word%0d: addr=%h data=%h required %h", i, addr_q[i], data_q[i], ea);
      end
      ea = ea + 14'd1;
    end
  endtask

  task automatic test_backpressure();
    bit ok = 1'b1;
    clear_mon();
    st_ready = 1'b0;
    pulse_start(14'h0200, 14'd20);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      @(posedge clk); #1 st_ready = ($urandom_range(0, 9) < 3);
    end
    st_ready = 1'b1;
    wait_done(20, "bp");
    checks++;
    if (data_q.size() != 20 || done_cnt != 1) begin
      failures++;
      $display("FAIL bp_count: words=%0d done=%0d required 20/1", data_q.size(), done_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      if (data_q[i] !== 32'h200 + 32'(i) || last_q[i] !== (i == 19)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_order: first=%h required 200..213 in order with last on final", data_q[0]);
    end
    checks++;
    if (credit_viol != 0) begin
      failures++;
      $display("FAIL bp_credit: %0d requests with 4 outstanding required 0", credit_viol);
    end
  endtask

  task automatic test_restart_ignored();
    bit ok = 1'b1;
    clear_mon();
    st_ready = 1'b1;
    pulse_start(14'h0040, 14'd10);
    @(posedge clk);
    pulse_start(14'h0100, 14'd5);
    wait_done(60, "restart");
    for (int i = 0; i < 10; i++) begin
      if (data_q[i] !== 32'h40 + 32'(i) || addr_q[i] !== 14'h40 + 14'(i)) ok = 1'b0;
    end
    checks++;
    if (!ok || data_q.size() != 10 || done_cnt != 1) begin
      failures++;
      $display("FAIL restart_seq: words=%0d done=%0d first=%h required 10/1/40", data_q.size(), done_cnt, data_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    clear_mon();
    st_ready = 1'b1;
    pulse_start(14'h0080, 14'd10);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (accepted >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL rst_mid_progress: %0d words accepted required 3", accepted);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    checks++;
    if ({busy, done, m_chipselect, st_valid, st_last} !== 5'b0 || st_data !== 32'h0 || m_address !== 14'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs: ctrl=%b data=%h addr=%h required 0", {busy, done, m_chipselect, st_valid, st_last}, st_data, m_address);
    end
    repeat (5) @(posedge clk);
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL rst_mid_nodone: %0d done pulses required 0", done_cnt);
    end
    clear_mon();
    pulse_start(14'h0030, 14'd2);
    wait_done(30, "rst_after");
    checks++;
    if (data_q.size() != 2 || data_q[0] !== 32'h30 || data_q[1] !== 32'h31 || last_q[1] !== 1'b1) begin
      failures++;
      $display("FAIL rst_after_words: n=%0d w0=%h w1=%h required 2/30/31", data_q.size(), data_q[0], data_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
